dense_layer_sequencer: RTL

Time-multiplexed controller for one dense layer. It computes result[b][m] = (sum over j of weights[m][j]*inputs[b][j]) >>> FRAC using a single multiply-accumulate unit instead of B*M*N parallel multipliers. It fetches operands from external weight and input memories (row-major, 1-cycle read latency) and streams results out over a valid/ready interface. It sits between the layer's operand memories and the next layer or activation stage, under a top-level start/done controller.

---
 rtl/dense_pkg.sv | 28 ++
 rtl/mac_unit.sv | 32 +++
 rtl/dense_layer_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dense_pkg.sv
// Shared types and constants for the dense-layer sequencer; no logic, no latency.
// Holds the default layer geometry and the fixed-point shift helper used by the result path.
package dense_pkg;

  localparam int DEF_B     = 2;
  localparam int DEF_M     = 3;
  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;

  localparam int ACC_W = 2 * DEF_WIDTH;
  localparam int WA_W  = $clog2(DEF_M * DEF_N);
  localparam int XA_W  = $clog2(DEF_B * DEF_N);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    FLUSH = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Arithmetic right shift (floor toward -inf); the caller truncates to its result width.
  function automatic logic [63:0] fx_shift(input logic signed [63:0] v, input int frac);
    return 64'(v >>> frac);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed WIDTH x WIDTH multiply into a wrapping 2*WIDTH accumulator; product lands 1 cycle after en.
// No flow control: clr wins over en, and the accumulator holds whenever en is low.
module mac_unit
  import dense_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = 2 * DEF_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [AW-1:0]   acc
);

  logic signed [AW-1:0] prod;

  assign prod = AW'($signed(a)) * AW'($signed(b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: rtl/dense_layer_sequencer.sv
// Time-multiplexed dense layer: one MAC, N+2 cycles per result, results in (b outer, m inner) order.
// Result outputs hold while res_valid && !res_ready; no reads are issued during back-pressure.
module dense_layer_sequencer
  import dense_pkg::*;
#(
  parameter int B     = DEF_B,
  parameter int M     = DEF_M,
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                rd_en,
  output logic [$clog2(M*N)-1:0]              w_addr,
  input  logic [WIDTH-1:0]                    w_rdata,
  output logic [$clog2(B*N)-1:0]              x_addr,
  input  logic [WIDTH-1:0]                    x_rdata,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [WIDTH-1:0]                    res_data,
  output logic [((B > 1) ? $clog2(B) : 1)-1:0] res_b,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] res_m
);

  localparam int AW  = 2 * WIDTH;
  localparam int WAW = $clog2(M * N);
  localparam int XAW = $clog2(B * N);
  localparam int BW  = (B > 1) ? $clog2(B) : 1;
  localparam int MW  = (M > 1) ? $clog2(M) : 1;
  localparam int JW  = (N > 1) ? $clog2(N) : 1;

  state_t        state, state_n;
  logic [BW-1:0] b_q, b_n;
  logic [MW-1:0] m_q, m_n;
  logic [JW-1:0] j_q, j_n;
  logic          acc_clr;
  logic          rd_vld;
  logic [AW-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      b_q    <= '0;
      m_q    <= '0;
      j_q    <= '0;
      rd_vld <= 1'b0;
      w_addr <= '0;
      x_addr <= '0;
    end else begin
      state  <= state_n;
      b_q    <= b_n;
      m_q    <= m_n;
      j_q    <= j_n;
      rd_vld <= rd_en;
      // Addresses only move when a read is about to be issued, so they hold otherwise.
      if (state_n == MAC) begin
        w_addr <= WAW'(int'(m_n) * N + int'(j_n));
        x_addr <= XAW'(int'(b_n) * N + int'(j_n));
      end
    end
  end

  always_comb begin
    state_n = state;
    b_n     = b_q;
    m_n     = m_q;
    j_n     = j_q;
    acc_clr = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = MAC;
          b_n     = '0;
          m_n     = '0;
          j_n     = '0;
          acc_clr = 1'b1;
        end
      end
      MAC: begin
        if (j_q == JW'(N - 1)) begin
          state_n = FLUSH;
        end else begin
          j_n = j_q + 1'b1;
        end
      end
      FLUSH: state_n = OUT;
      OUT: begin
        if (res_ready) begin
          acc_clr = 1'b1;
          j_n     = '0;
          if (m_q == MW'(M - 1)) begin
            m_n = '0;
            b_n = (b_q == BW'(B - 1)) ? '0 : b_q + 1'b1;
          end else begin
            m_n = m_q + 1'b1;
          end
          state_n = (b_q == BW'(B - 1) && m_q == MW'(M - 1)) ? DONE : MAC;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rd_en     = (state == MAC);
  assign res_valid = (state == OUT);
  // acc, b_q and m_q only change on a handshake, so these are stable under back-pressure.
  assign res_data  = WIDTH'(fx_shift(64'($signed(acc)), FRAC));
  assign res_b     = b_q;
  assign res_m     = m_q;

  mac_unit #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (rd_vld),
    .a     (w_rdata),
    .b     (x_rdata),
    .acc   (acc)
  );

endmodule
